// File: rtl/output_sequencer.sv
// Run-level sequencer for the projection-result output stage: clear, compute, stream words per sample.
// Optional WAIT watchdog enabled by defining OUTPUT_SEQUENCER_TIMEOUT_EN.
module output_sequencer #(
    parameter int unsigned NUM_WEIGHTS    = 400,
    parameter int unsigned NUM_SAMPLES    = 400,
    parameter int unsigned IDX_W          = 9,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             comp_start,
    input  logic             comp_done,
    output logic [IDX_W-1:0] sample_iter,
    output logic [IDX_W-1:0] weight_iter,
    output logic             out_enable,
    output logic             out_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             frame_done,
    output logic             err_timeout
);

    localparam logic [IDX_W-1:0] W_LAST = IDX_W'(NUM_WEIGHTS - 1);
    localparam logic [IDX_W-1:0] S_LAST = IDX_W'(NUM_SAMPLES - 1);

    if (IDX_W == 0 || NUM_WEIGHTS == 0 || NUM_SAMPLES == 0 || TIMEOUT_CYCLES == 0 ||
        (64'(1) << IDX_W) < 64'(NUM_WEIGHTS) || (64'(1) << IDX_W) < 64'(NUM_SAMPLES)) begin : g_bad_params
        $error("output_sequencer: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COMPUTE,
        ST_WAIT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    logic   issue;

`ifdef OUTPUT_SEQUENCER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // A word may be issued whenever the output slot is empty or being drained this cycle.
    assign issue      = !out_valid || out_ready;
    assign out_enable = (state == ST_STREAM) && issue;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sample_iter <= '0;
            weight_iter <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            comp_start  <= 1'b0;
            out_clear   <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
`ifdef OUTPUT_SEQUENCER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            comp_start  <= 1'b0;
            out_clear   <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;

            // Valid/last track the stage's one-cycle load latency and hold under stall.
            if (out_enable) begin
                out_valid <= 1'b1;
                out_last  <= (weight_iter == W_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        out_clear <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    sample_iter <= '0;
                    weight_iter <= '0;
                    comp_start  <= 1'b1;
                    state       <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    state <= ST_WAIT;
`ifdef OUTPUT_SEQUENCER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (comp_done) begin
                        weight_iter <= '0;
                        state       <= ST_STREAM;
                    end
`ifdef OUTPUT_SEQUENCER_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        sample_iter <= '0;
                        weight_iter <= '0;
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_STREAM: begin
                    if (issue) begin
                        if (weight_iter == W_LAST) begin
                            state <= ST_DRAIN;
                        end else begin
                            weight_iter <= weight_iter + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (sample_iter == S_LAST) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            sample_iter <= sample_iter + IDX_W'(1);
                            weight_iter <= '0;
                            comp_start  <= 1'b1;
                            state       <= ST_COMPUTE;
                        end
                    end
                end
                ST_DONE: begin
                    sample_iter <= '0;
                    weight_iter <= '0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_sequencer.sv
// Scoreboard bench for output_sequencer: models the datapath and the output stage, checks every accepted word.
module tb_output_sequencer;

    localparam int unsigned NW = 4;
    localparam int unsigned NS = 2;
    localparam int unsigned IW = 3;
    localparam int unsigned TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          comp_start;
    logic          comp_done;
    logic [IW-1:0] sample_iter;
    logic [IW-1:0] weight_iter;
    logic          out_enable;
    logic          out_clear;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic          err_timeout;

    output_sequencer #(
        .NUM_WEIGHTS(NW), .NUM_SAMPLES(NS), .IDX_W(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .comp_start(comp_start), .comp_done(comp_done),
        .sample_iter(sample_iter), .weight_iter(weight_iter),
        .out_enable(out_enable), .out_clear(out_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          accepted = 0;
    int          run_comp = 0;
    bit          dp_en    = 1'b1;
    logic [31:0] stage_data;

    function automatic logic [31:0] word_of(input int s, input int w);
        return 32'hA000_0000 | (32'(s) << 16) | 32'(w);
    endfunction

    // Output register stage model: one-cycle load latency, holds while enable is low.
    always @(posedge clk) begin
        if (rst || out_clear) stage_data <= '0;
        else if (out_enable) stage_data <= word_of(int'(sample_iter), int'(weight_iter));
    end

    task automatic push_sample(input int s);
        for (int w = 0; w < int'(NW); w++) begin
            exp_t e;
            e.data = word_of(s, w);
            e.last = (w == int'(NW) - 1);
            exp_q.push_back(e);
        end
    endtask

    // Datapath model: comp_done three cycles after comp_start; expected words queued at that point.
    initial begin : dp_model
        int cnt   = 0;
        int smp   = 0;
        bit fired = 1'b0;
        forever begin
            @(negedge clk);
            if (fired) begin
                comp_done = 1'b0;
                fired     = 1'b0;
            end
            if (rst || !dp_en) begin
                cnt = 0;
            end else if (comp_start) begin
                cnt = 3;
                smp = run_comp;
                run_comp++;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    push_sample(smp);
                    comp_done = 1'b1;
                    fired     = 1'b1;
                end
            end
        end
    end

    // Consumer: every handshake pops one expected word.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                accepted++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL word_unexpected: got data=%h last=%b, expected no word", stage_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({stage_data, out_last} !== {e.data, e.last}) begin
                        failures++;
                        $display("FAIL word: got data=%h last=%b, expected data=%h last=%b",
                                 stage_data, out_last, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        exp_q.delete();
        accepted = 0;
        run_comp = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, output int fd);
        bit seen;
        fd   = 0;
        seen = 1'b0;
        for (int b = 0; b < 300; b++) begin
            tick();
            if (frame_done) begin
                fd++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (!seen || busy !== 1'b0 || frame_done !== 1'b0 || sample_iter !== '0) begin
            failures++;
            $display("FAIL %s_end: got seen=%0b busy=%b frame_done=%b sample_iter=%0d, expected 1 0 0 0",
                     name, seen, busy, frame_done, sample_iter);
        end
    endtask

    task automatic check_run(input string name, input int fd);
        checks++;
        if (fd != 1) begin
            failures++;
            $display("FAIL %s_frame_done: got %0d pulses, expected 1", name, fd);
        end
        checks++;
        if (accepted != int'(NW * NS) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_words: got accepted=%0d pending=%0d, expected %0d and 0",
                     name, accepted, exp_q.size(), NW * NS);
        end
    endtask

    task automatic wait_valid(input string name, input int s, input int w);
        bit ok = 1'b0;
        for (int b = 0; b < 100; b++) begin
            if (out_valid && int'(sample_iter) == s && (w < 0 || int'(weight_iter) == w)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_wait: got no valid word for sample %0d, expected one within 100 cycles", name, s);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        comp_done = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        checks++;
        if (out_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_enable: got %b, expected 0", out_enable);
        end
        checks++;
        if ({out_valid, out_last, comp_start, out_clear, frame_done, err_timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_regs: got %b, expected 000000",
                     {out_valid, out_last, comp_start, out_clear, frame_done, err_timeout});
        end
        checks++;
        if (sample_iter !== '0 || weight_iter !== '0) begin
            failures++;
            $display("FAIL reset_idx: got s=%0d w=%0d, expected 0 0", sample_iter, weight_iter);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        int fd;
        begin_run();
        checks++;
        if (out_clear !== 1'b1 || busy !== 1'b1 || comp_start !== 1'b0) begin
            failures++;
            $display("FAIL basic_clear: got clear=%b busy=%b comp_start=%b, expected 1 1 0",
                     out_clear, busy, comp_start);
        end
        tick();
        checks++;
        if (comp_start !== 1'b1 || out_clear !== 1'b0) begin
            failures++;
            $display("FAIL basic_comp_start: got comp_start=%b clear=%b, expected 1 0", comp_start, out_clear);
        end
        finish_run("basic", fd);
        check_run("basic", fd);
        checks++;
        if (run_comp != int'(NS)) begin
            failures++;
            $display("FAIL basic_comp_count: got %0d comp_start pulses, expected %0d", run_comp, NS);
        end
    endtask

    task automatic test_backpressure();
        int            fd;
        logic [IW-1:0] w_hold;
        bit            ok;
        begin_run();
        wait_valid("bp", 0, 2);
        out_ready = 1'b0;
        w_hold    = weight_iter;
        ok        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_enable !== 1'b0 || weight_iter !== w_hold) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_stall: got valid=%b enable=%b w=%0d, expected 1 0 %0d",
                     out_valid, out_enable, weight_iter, w_hold);
        end
        out_ready = 1'b1;
        finish_run("bp", fd);
        check_run("bp", fd);
    endtask

    task automatic test_start_and_done_ignored();
        int fd;
        begin_run();
        wait_valid("ign", 0, -1);
        start = 1'b1;
        tick();
        start     = 1'b0;
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
        finish_run("ign", fd);
        check_run("ign", fd);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL ign_restart: got busy=%b frame_done=%b, expected 0 0", busy, frame_done);
        end
        accepted  = 0;
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || accepted != 0) begin
            failures++;
            $display("FAIL idle_comp_done: got busy=%b valid=%b words=%0d, expected 0 0 0",
                     busy, out_valid, accepted);
        end
    endtask

    task automatic test_reset_mid_run();
        int fd;
        begin_run();
        wait_valid("rst", 1, -1);
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, out_enable, out_valid, out_last, comp_start, out_clear, frame_done, err_timeout} !== 8'b0
            || sample_iter !== '0 || weight_iter !== '0) begin
            failures++;
            $display("FAIL rst_mid: got ctl=%b s=%0d w=%0d, expected 00000000 0 0",
                     {busy, out_enable, out_valid, out_last, comp_start, out_clear, frame_done, err_timeout},
                     sample_iter, weight_iter);
        end
        rst = 1'b0;
        tick();
        begin_run();
        finish_run("rerun", fd);
        check_run("rerun", fd);
    endtask

`ifdef OUTPUT_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout();
        int fd;
        dp_en = 1'b0;
        begin_run();
        tick();
        for (int k = 1; k <= 10; k++) tick();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL to_early: got err=%b busy=%b, expected 0 1", err_timeout, busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || sample_iter !== '0) begin
            failures++;
            $display("FAIL to_expire: got err=%b busy=%b s=%0d, expected 1 0 0", err_timeout, busy, sample_iter);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_pulse: got err=%b, expected 0", err_timeout);
        end
        begin_run();
        tick();
        for (int k = 1; k <= 10; k++) tick();
        push_sample(0);
        run_comp  = 1;
        dp_en     = 1'b1;
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1 || out_enable !== 1'b1) begin
            failures++;
            $display("FAIL to_race: got err=%b busy=%b enable=%b, expected 0 1 1", err_timeout, busy, out_enable);
        end
        finish_run("to_race", fd);
        check_run("to_race", fd);
    endtask
`else
    task automatic test_wait_hold();
        int fd;
        bit ok = 1'b1;
        dp_en = 1'b0;
        begin_run();
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy !== 1'b1 || err_timeout !== 1'b0 || out_valid !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_hold: got busy=%b err=%b valid=%b, expected 1 0 0", busy, err_timeout, out_valid);
        end
        push_sample(0);
        run_comp  = 1;
        dp_en     = 1'b1;
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
        finish_run("wait", fd);
        check_run("wait", fd);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_backpressure();
        test_start_and_done_ignored();
        test_reset_mid_run();
`ifdef OUTPUT_SEQUENCER_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_sequencer.md
Name: output_sequencer

Overview:
- Controller that sequences the projection-result output stage across a full recognition run.
- Per sample: clears the output stage, triggers the compute datapath and waits for its completion.
- Then walks the weight index 0..NUM_WEIGHTS-1 to stream one 32-bit result word per index to a downstream valid/ready consumer.
- Sits between the top-level control/host interface, the compute datapath and the output register stage. Drives that stage's enable, clear, sample_iter and weight_iter inputs.

Parameters:
- NUM_WEIGHTS, 400, result words per sample; weight index range 0..NUM_WEIGHTS-1.
- NUM_SAMPLES, 400, samples per run; sample index range 0..NUM_SAMPLES-1.
- IDX_W, 9, width of both index outputs; must satisfy 2^IDX_W >= max(NUM_WEIGHTS, NUM_SAMPLES).
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run when idle.
- busy  out  1  high in every state except IDLE.
- comp_start  out  1  one-cycle pulse to the datapath: compute the current sample.
- comp_done  in  1  pulse from the datapath: results for the current sample are ready.
- sample_iter  out  IDX_W  current sample index, registered.
- weight_iter  out  IDX_W  current weight index, registered.
- out_enable  out  1  output-stage load strobe, combinational.
- out_clear  out  1  output-stage clear strobe.
- out_valid  out  1  downstream word valid; aligned with the output stage's data_out.
- out_ready  in  1  downstream accept.
- out_last  out  1  qualifies out_valid; marks the final word of a sample.
- frame_done  out  1  one-cycle pulse when the run completes.
- err_timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 when the feature is absent.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; sample_iter=0, weight_iter=0. Registered outputs (out_valid, out_last, comp_start, out_clear, frame_done, err_timeout) reset to 0. busy and out_enable decode to 0 in IDLE. Reset mid-run abandons the run with no drain.
- The output stage has one-cycle load latency: out_enable high at cycle t with weight_iter=w gives data_out=R[w] at t+1. out_valid is therefore a 1-cycle delayed copy of the issue.
- IDLE: start=1 -> CLEAR. start is ignored in all other states.
- CLEAR: one cycle with out_clear=1; sample_iter and weight_iter forced to 0 -> COMPUTE.
- COMPUTE: one cycle with comp_start=1 -> WAIT.
- WAIT: hold until comp_done=1 -> STREAM with weight_iter=0. comp_done is ignored outside WAIT.
- STREAM: issue = !out_valid || out_ready, and out_enable = issue.
  - On issue with weight_iter<NUM_WEIGHTS-1: weight_iter+1.
  - On issue with weight_iter==NUM_WEIGHTS-1: -> DRAIN; weight_iter holds.
- out_valid update:
  - Set when out_enable=1.
  - Else cleared when out_ready=1.
  - Else held (stall holds data because the stage holds data_out while enable is low).
- out_last: registered with out_valid as (out_enable && weight_iter==NUM_WEIGHTS-1). Held under stall.
- DRAIN: out_enable=0; wait for out_valid && out_ready (last word accepted).
  - If sample_iter==NUM_SAMPLES-1: -> DONE.
  - Else: sample_iter+1, weight_iter=0, -> COMPUTE.
  - No clear is issued between samples; only CLEAR at run start.
- DONE: frame_done=1 for one cycle; sample_iter and weight_iter reset to 0 -> IDLE.
- Indices never wrap past their limits; increment is guarded by the terminal-value compare.
- Throughput: with out_ready held high, one word per cycle. Sample overhead is 2 cycles (DRAIN, COMPUTE) plus datapath latency.

Optional Feature:
- Macro: OUTPUT_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT; it is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without comp_done: err_timeout pulses 1 cycle, state -> IDLE, indices reset to 0, out_valid cleared.
  - comp_done in the same cycle as expiry wins: normal transition to STREAM, no error.
- Undefined: no counter logic; WAIT holds indefinitely; err_timeout tied 0.

Test Plan:
- NUM_WEIGHTS=4, NUM_SAMPLES=2; start at cycle 0, comp_done 3 cycles after each comp_start, out_ready=1:
  - Required: out_clear at cycle 1, comp_start at cycle 2.
  - Sample 0: out_valid with weight_iter 0,1,2,3 sequence and out_last on the 4th word.
  - Second comp_start, then sample_iter=1 words; frame_done once; busy falls the same cycle DONE exits.
- Backpressure, same params: out_ready=0 for 3 cycles mid-stream.
  - Required: out_valid stays 1, out_enable=0, weight_iter frozen.
  - Words are not duplicated or skipped; total 8 accepted words.
- start pulsed during STREAM -> ignored; exactly one frame_done per run.
- rst=1 during STREAM of sample 1 -> next cycle: state IDLE, all outputs 0, busy=0. A later start runs a clean full sequence.
- comp_done pulsed in STREAM and in IDLE -> no state change, no extra words.
- With OUTPUT_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=10, comp_done never asserted -> err_timeout 10 cycles after WAIT entry, busy=0 the following cycle. Second variant: comp_done on the expiry cycle -> no error, streaming starts.
